// File: rtl/lcd_line_composer.sv
// lcd_line_composer: binary-to-decimal/hex formatter for a 16x2 text LCD.
// Optional macro LCD_ZERO_BLANK_EN blanks leading decimal zeros on line1.
module lcd_line_composer (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [15:0]  value,
    output logic [127:0] line1,
    output logic [127:0] line2,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PACK  = 2'd2
    } state_t;

    localparam logic [127:0] BLANK    = {16{8'h20}};
    localparam logic [31:0]  DEC_TAG  = 32'h4445_433A;
    localparam logic [31:0]  HEX_TAG  = 32'h4845_583A;

    state_t        state_q, state_d;
    logic [15:0]   value_q, value_d;
    logic [15:0]   bin_q, bin_d;
    logic [19:0]   bcd_q, bcd_d;
    logic [19:0]   bcd_adj;
    logic [4:0]    cnt_q, cnt_d;
    logic [127:0]  line1_q, line1_d;
    logic [127:0]  line2_q, line2_d;
    logic          done_q;
    logic [7:0]    dch [5];
    logic [3:0]    blank;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n < 4'd10) begin
            return 8'h30 + {4'h0, n};
        end
        return 8'h37 + {4'h0, n};
    endfunction

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: 1 accept edge, 16 shift edges, 1 pack edge
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (cnt_q == 5'd1) state_d = PACK;
            PACK:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy  = (state_q != IDLE);
        done  = done_q;
        line1 = line1_q;
        line2 = line2_q;
    end

    // Double-dabble correction: add 3 to every BCD nibble that is >= 5
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 5; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
            end
        end
    end

    // Datapath next-state: latch operand on start, shift during SHIFT
    always_comb begin
        value_d = value_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    value_d = value;
                    bin_d   = value;
                    bcd_d   = '0;
                    cnt_d   = 5'd16;
                end
            end
            SHIFT: begin
                {bcd_d, bin_d} = {bcd_adj[18:0], bin_q, 1'b0};
                cnt_d          = cnt_q - 5'd1;
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value_q <= '0;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
        end else begin
            value_q <= value_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
        end
    end

    // Leading-zero blanking mask for the four upper decimal digits
    always_comb begin
        blank = '0;
`ifdef LCD_ZERO_BLANK_EN
        blank[3] = (bcd_q[19:16] == 4'd0);
        blank[2] = blank[3] && (bcd_q[15:12] == 4'd0);
        blank[1] = blank[2] && (bcd_q[11:8] == 4'd0);
        blank[0] = blank[1] && (bcd_q[7:4] == 4'd0);
`endif
    end

    // Text formatting of both lines from the finished BCD and latched value
    always_comb begin
        dch[0] = blank[3] ? 8'h20 : {4'h3, bcd_q[19:16]};
        dch[1] = blank[2] ? 8'h20 : {4'h3, bcd_q[15:12]};
        dch[2] = blank[1] ? 8'h20 : {4'h3, bcd_q[11:8]};
        dch[3] = blank[0] ? 8'h20 : {4'h3, bcd_q[7:4]};
        dch[4] = {4'h3, bcd_q[3:0]};
        line1_d = {DEC_TAG, dch[0], dch[1], dch[2], dch[3], dch[4],
                   {7{8'h20}}};
        line2_d = {HEX_TAG,
                   hex_char(value_q[15:12]), hex_char(value_q[11:8]),
                   hex_char(value_q[7:4]),   hex_char(value_q[3:0]),
                   {8{8'h20}}};
    end

    // Line registers update only in PACK and otherwise hold steady
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            line1_q <= BLANK;
            line2_q <= BLANK;
            done_q  <= 1'b0;
        end else begin
            done_q <= (state_q == PACK);
            if (state_q == PACK) begin
                line1_q <= line1_d;
                line2_q <= line2_d;
            end
        end
    end

endmodule

// File: tb/tb_lcd_line_composer.sv
// tb_lcd_line_composer: randomized and directed bench with a
// timestamp-based reference model of the formatter.
module tb_lcd_line_composer;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [15:0]  value;
    logic [127:0] line1;
    logic [127:0] line2;
    logic         busy;
    logic         done;

    int tests = 0;
    int fails = 0;

    localparam logic [127:0] BLANK = {16{8'h20}};

    int           edge_n  = 0;
    int           done_at = -1;
    int           last_done = -1;
    logic [15:0]  lat = '0;
    logic [127:0] e1 = BLANK;
    logic [127:0] e2 = BLANK;
    logic         ed = 1'b0;
    logic         eb = 1'b0;

    lcd_line_composer dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .value (value),
        .line1 (line1),
        .line2 (line2),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] push(input logic [127:0] r,
                                          input logic [7:0] c);
        return {r[119:0], c};
    endfunction

    function automatic logic [127:0] exp_dec(input int v);
        logic [127:0] r;
        int           d[5];
        bit           lead;
        logic [7:0]   ch;
        r = '0;
        r = push(r, "D"); r = push(r, "E");
        r = push(r, "C"); r = push(r, ":");
        d[0] = (v / 10000) % 10;
        d[1] = (v / 1000) % 10;
        d[2] = (v / 100) % 10;
        d[3] = (v / 10) % 10;
        d[4] = v % 10;
        lead = 1'b1;
        for (int k = 0; k < 5; k++) begin
            ch = 8'(48 + d[k]);
`ifdef LCD_ZERO_BLANK_EN
            if (lead && d[k] == 0 && k < 4) ch = 8'h20;
            else lead = 1'b0;
`endif
            r = push(r, ch);
        end
        for (int k = 0; k < 7; k++) r = push(r, 8'h20);
        return r;
    endfunction

    function automatic logic [127:0] exp_hex(input int v);
        logic [127:0] r;
        string        hx;
        int           n;
        hx = "0123456789ABCDEF";
        r = '0;
        r = push(r, "H"); r = push(r, "E");
        r = push(r, "X"); r = push(r, ":");
        for (int k = 3; k >= 0; k--) begin
            n = (v >> (4 * k)) & 15;
            r = push(r, hx[n]);
        end
        for (int k = 0; k < 8; k++) r = push(r, 8'h20);
        return r;
    endfunction

    task automatic model_reset();
        done_at = -1;
        e1 = BLANK;
        e2 = BLANK;
        ed = 1'b0;
        eb = 1'b0;
    endtask

    task automatic model_edge(input bit st, input logic [15:0] v);
        edge_n++;
        ed = 1'b0;
        if (reset) begin
            model_reset();
            return;
        end
        if (done_at < 0) begin
            if (st) begin
                lat = v;
                done_at = edge_n + 17;
            end
        end else if (edge_n == done_at) begin
            e1 = exp_dec(int'(lat));
            e2 = exp_hex(int'(lat));
            ed = 1'b1;
            done_at = -1;
        end
        eb = (done_at >= 0);
    endtask

    task automatic check_all();
        check("busy",  {127'b0, busy}, {127'b0, eb});
        check("done",  {127'b0, done}, {127'b0, ed});
        check("line1", line1, e1);
        check("line2", line2, e2);
    endtask

    task automatic step(input bit st, input logic [15:0] v);
        start = st;
        value = v;
        @(posedge clk);
        model_edge(st, v);
        #1;
        check_all();
    endtask

    task automatic conv(input logic [15:0] v);
        step(1'b1, v);
        repeat (17) step(1'b0, 16'($urandom));
        step(1'b0, 16'($urandom));
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        value = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        reset = 1'b0;

        conv(16'h0000);
        conv(16'hFFFF);
        conv(16'h1234);

        step(1'b1, 16'd100);
        repeat (4) step(1'b0, 16'd55);
        step(1'b1, 16'd200);
        repeat (13) step(1'b0, 16'd200);

        step(1'b1, 16'd999);
        repeat (8) step(1'b0, 16'd1);
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        reset = 1'b0;
        conv(16'h00AB);

        repeat (400) step($urandom_range(0, 3) == 0, 16'($urandom));
        repeat (18) step(1'b0, 16'($urandom));

        last_done = -1;
        repeat (80) begin
            step(1'b1, 16'd7);
            if (done) begin
                if (last_done >= 0) begin
                    check("interval", 128'(edge_n - last_done), 128'd18);
                end
                last_done = edge_n;
            end
        end
        start = 1'b0;
        repeat (20) step(1'b0, 16'($urandom));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
